// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, the latched
// request record and the default starvation bound.
package dmem_port_arbiter_pkg;

    localparam int DMEM_WORD_W       = 16;
    localparam int DMEM_TAG_W        = 4;
    localparam int DMEM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        LD_REQ  = 2'd2,
        LD_WAIT = 2'd3
    } dmem_arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_WORD_W-1:0] addr;
        logic [DMEM_WORD_W-1:0] data;
        logic [DMEM_TAG_W-1:0]  tag;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Single-outstanding arbiter between store-buffer drain and load misses on the
// data-memory port. Field widths of dmem_req_t follow the package defaults.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE_P  = DMEM_WORD_W,
    parameter int LD_TAG_W     = DMEM_TAG_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   rob_mispredict_i,
    input  logic                   st_v_i,
    input  logic [WORD_SIZE_P-1:0] st_addr_i,
    input  logic [WORD_SIZE_P-1:0] st_data_i,
    input  logic                   st_urgent_i,
    output logic                   st_ready_o,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    input  logic [LD_TAG_W-1:0]    ld_tag_i,
    output logic                   ld_ready_o,
    output logic                   ld_resp_v_o,
    output logic [WORD_SIZE_P-1:0] ld_resp_data_o,
    output logic [LD_TAG_W-1:0]    ld_resp_tag_o,
    output logic                   mem_v_o,
    output logic                   mem_we_o,
    output logic [WORD_SIZE_P-1:0] mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_data_o,
    input  logic                   mem_ready_i,
    input  logic                   mem_resp_v_i,
    input  logic [WORD_SIZE_P-1:0] mem_resp_data_i
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    dmem_arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                   kill_q, kill_d;
    dmem_req_t              req_q, req_d;
    logic                   resp_v_q, resp_v_d;
    logic [WORD_SIZE_P-1:0] resp_data_q, resp_data_d;
    logic [LD_TAG_W-1:0]    resp_tag_q, resp_tag_d;

    logic ld_ok;
    logic st_pri;
    logic st_grant;
    logic ld_grant;

    // A mispredict blocks new loads; a waiting store wins when urgent or starved.
    always_comb begin
        ld_ok    = ld_v_i & ~rob_mispredict_i;
        st_pri   = st_urgent_i | (starve_cnt_q == LIMIT);
        st_grant = 1'b0;
        ld_grant = 1'b0;
        if (state_q == IDLE) begin
            st_grant = st_v_i & (st_pri | ~ld_ok);
            ld_grant = ld_ok & ~st_grant;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        kill_d       = kill_q;
        req_d        = req_q;
        resp_v_d     = 1'b0;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (st_grant) begin
                    state_d      = ST_REQ;
                    req_d.we     = 1'b1;
                    req_d.addr   = st_addr_i;
                    req_d.data   = st_data_i;
                    req_d.tag    = '0;
                    starve_cnt_d = '0;
                end else if (ld_grant) begin
                    state_d    = LD_REQ;
                    req_d.we   = 1'b0;
                    req_d.addr = ld_addr_i;
                    req_d.data = '0;
                    req_d.tag  = ld_tag_i;
                    if (st_v_i && starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
                if (!st_v_i) begin
                    starve_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            LD_REQ: begin
                if (rob_mispredict_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (mem_resp_v_i) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !rob_mispredict_i) begin
                        resp_v_d    = 1'b1;
                        resp_data_d = mem_resp_data_i;
                        resp_tag_d  = req_q.tag;
                    end
                end else if (rob_mispredict_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            kill_q       <= 1'b0;
            req_q        <= '0;
            resp_v_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            kill_q       <= kill_d;
            req_q        <= req_d;
            resp_v_q     <= resp_v_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign st_ready_o     = st_grant;
    assign ld_ready_o     = ld_grant;
    assign mem_v_o        = (state_q == ST_REQ) || (state_q == LD_REQ);
    assign mem_we_o       = mem_v_o & req_q.we;
    assign mem_addr_o     = req_q.addr;
    assign mem_data_o     = req_q.data;
    assign ld_resp_v_o    = resp_v_q;
    assign ld_resp_data_o = resp_data_q;
    assign ld_resp_tag_o  = resp_tag_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: IDLE arbitration table plus hand-built
// store, load, starvation, urgent, mispredict and reset sequences.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        rob_mispredict_i = 1'b0;
    logic        st_v_i = 1'b0;
    logic [15:0] st_addr_i = '0;
    logic [15:0] st_data_i = '0;
    logic        st_urgent_i = 1'b0;
    logic        st_ready_o;
    logic        ld_v_i = 1'b0;
    logic [15:0] ld_addr_i = '0;
    logic [3:0]  ld_tag_i = '0;
    logic        ld_ready_o;
    logic        ld_resp_v_o;
    logic [15:0] ld_resp_data_o;
    logic [3:0]  ld_resp_tag_o;
    logic        mem_v_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_resp_v_i = 1'b0;
    logic [15:0] mem_resp_data_i = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.WORD_SIZE_P(16), .LD_TAG_W(4), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .rob_mispredict_i(rob_mispredict_i),
        .st_v_i(st_v_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_urgent_i(st_urgent_i), .st_ready_o(st_ready_o),
        .ld_v_i(ld_v_i), .ld_addr_i(ld_addr_i), .ld_tag_i(ld_tag_i),
        .ld_ready_o(ld_ready_o), .ld_resp_v_o(ld_resp_v_o),
        .ld_resp_data_o(ld_resp_data_o), .ld_resp_tag_o(ld_resp_tag_o),
        .mem_v_o(mem_v_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i)
    );

    typedef struct {
        logic st_v;
        logic ld_v;
        logic urg;
        logic mp;
        logic exp_st_rdy;
        logic exp_ld_rdy;
    } arb_vec_t;

    arb_vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        st_v_i = 1'b0; ld_v_i = 1'b0; st_urgent_i = 1'b0; rob_mispredict_i = 1'b0;
        mem_ready_i = 1'b0; mem_resp_v_i = 1'b0;
    endtask

    // Load handshake, accept, response two cycles after accept.
    task automatic run_load(input logic [15:0] addr, input logic [3:0] tag,
                            input logic [15:0] rdata, input logic mp_wait, input logic mp_same);
        @(negedge clk);
        ld_v_i = 1'b1; ld_addr_i = addr; ld_tag_i = tag;
        #1 chk("ld_handshake", ld_ready_o, 1'b1);
        @(negedge clk);
        ld_v_i = 1'b0;
        #1 chk("ld_req_v", mem_v_o, 1'b1);
        chk("ld_req_we", mem_we_o, 1'b0);
        chk("ld_req_addr", mem_addr_o, addr);
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        rob_mispredict_i = mp_wait;
        #1 chk("ld_wait_v", mem_v_o, 1'b0);
        @(negedge clk);
        rob_mispredict_i = mp_same;
        mem_resp_v_i = 1'b1; mem_resp_data_i = rdata;
        #1 chk("ld_resp_early", ld_resp_v_o, 1'b0);
        @(negedge clk);
        mem_resp_v_i = 1'b0; rob_mispredict_i = 1'b0; mem_resp_data_i = '0;
    endtask

    initial begin
        int grants[10];
        int exp_g[10];
        int ng;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_g = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        #1 chk("rst_mem_v", mem_v_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 16'h0);
        chk("rst_mem_data", mem_data_o, 16'h0);
        chk("rst_resp_v", ld_resp_v_o, 1'b0);
        chk("rst_st_rdy", st_ready_o, 1'b0);
        chk("rst_ld_rdy", ld_ready_o, 1'b0);

        // IDLE arbitration table; inputs withdrawn before the edge so no grant is taken.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            st_v_i = vecs[i].st_v; ld_v_i = vecs[i].ld_v;
            st_urgent_i = vecs[i].urg; rob_mispredict_i = vecs[i].mp;
            #1 chk($sformatf("arb%0d_st_rdy", i), st_ready_o, vecs[i].exp_st_rdy);
            chk($sformatf("arb%0d_ld_rdy", i), ld_ready_o, vecs[i].exp_ld_rdy);
            #1 clear_inputs();
        end

        // Store held off by memory for three cycles.
        @(negedge clk);
        st_v_i = 1'b1; st_addr_i = 16'h0040; st_data_i = 16'hBEEF;
        #1 chk("st_handshake", st_ready_o, 1'b1);
        @(negedge clk);
        st_v_i = 1'b0; st_addr_i = 16'h1111; st_data_i = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("st_v_c%0d", i), mem_v_o, 1'b1);
            chk($sformatf("st_we_c%0d", i), mem_we_o, 1'b1);
            chk($sformatf("st_addr_c%0d", i), mem_addr_o, 16'h0040);
            chk($sformatf("st_data_c%0d", i), mem_data_o, 16'hBEEF);
            mem_ready_i = (i == 3);
            @(negedge clk);
        end
        mem_ready_i = 1'b0;
        #1 chk("st_idle_after", mem_v_o, 1'b0);

        // Plain load.
        run_load(16'h0010, 4'd5, 16'h1234, 1'b0, 1'b0);
        #1 chk("ld_resp_v", ld_resp_v_o, 1'b1);
        chk("ld_resp_data", ld_resp_data_o, 16'h1234);
        chk("ld_resp_tag", ld_resp_tag_o, 4'd5);
        @(negedge clk);
        #1 chk("ld_resp_pulse_end", ld_resp_v_o, 1'b0);

        // Starvation: both held, memory always ready and responding.
        @(negedge clk);
        st_v_i = 1'b1; ld_v_i = 1'b1; mem_ready_i = 1'b1; mem_resp_v_i = 1'b1;
        st_addr_i = 16'h00A0; ld_addr_i = 16'h00B0;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            #1;
            if (st_ready_o) begin grants[ng] = 2; ng++; end
            else if (ld_ready_o) begin grants[ng] = 1; ng++; end
            if (ng < 10) @(negedge clk);
        end
        clear_inputs();
        chk("starve_grant_count", ng, 10);
        for (int i = 0; i < 10 && i < ng; i++) chk($sformatf("starve_g%0d", i), grants[i], exp_g[i]);

        // Urgent store beats a load with an empty starvation count.
        @(negedge clk);
        @(negedge clk);
        st_v_i = 1'b1; ld_v_i = 1'b1; st_urgent_i = 1'b1; mem_ready_i = 1'b1;
        #1 chk("urg_st_rdy", st_ready_o, 1'b1);
        chk("urg_ld_rdy", ld_ready_o, 1'b0);
        @(negedge clk);
        st_urgent_i = 1'b0;
        #1 chk("urg_st_req_we", mem_we_o, 1'b1);
        @(negedge clk);
        #1 chk("urg_then_ld", ld_ready_o, 1'b1);
        #1 clear_inputs();

        // Mispredict while waiting for read data: response suppressed.
        run_load(16'h0020, 4'd3, 16'hAAAA, 1'b1, 1'b0);
        #1 chk("mp_wait_no_resp", ld_resp_v_o, 1'b0);
        // Mispredict in the same cycle as the response.
        run_load(16'h0030, 4'd6, 16'h5555, 1'b0, 1'b1);
        #1 chk("mp_same_no_resp", ld_resp_v_o, 1'b0);
        // Kill must have cleared: next load responds.
        run_load(16'h0034, 4'd7, 16'h7777, 1'b0, 1'b0);
        #1 chk("post_kill_resp_v", ld_resp_v_o, 1'b1);
        chk("post_kill_resp_tag", ld_resp_tag_o, 4'd7);
        chk("post_kill_resp_data", ld_resp_data_o, 16'h7777);

        // Mispredict during a store: write still issued.
        @(negedge clk);
        st_v_i = 1'b1; st_addr_i = 16'h0050; st_data_i = 16'hCAFE;
        @(negedge clk);
        st_v_i = 1'b0; rob_mispredict_i = 1'b1;
        #1 chk("mp_st_v", mem_v_o, 1'b1);
        chk("mp_st_we", mem_we_o, 1'b1);
        chk("mp_st_data", mem_data_o, 16'hCAFE);
        mem_ready_i = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1 chk("mp_st_done", mem_v_o, 1'b0);

        // Reset while in LD_WAIT abandons the load.
        @(negedge clk);
        ld_v_i = 1'b1; ld_addr_i = 16'h0060; ld_tag_i = 4'd9;
        @(negedge clk);
        ld_v_i = 1'b0; mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0; reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #1 chk("rst_wait_mem_v", mem_v_o, 1'b0);
        chk("rst_wait_resp_v", ld_resp_v_o, 1'b0);
        ld_v_i = 1'b1;
        #1 chk("rst_wait_idle", ld_ready_o, 1'b1);
        ld_v_i = 1'b0;
        mem_resp_v_i = 1'b1; mem_resp_data_i = 16'h9999;
        @(negedge clk);
        mem_resp_v_i = 1'b0;
        #1 chk("rst_stale_resp", ld_resp_v_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
